// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, rstatus codes and the writeback entry shared by the ALU writeback slice
package alu_pkg;
    localparam logic [4:0] OP_ADD      = 5'b00000;
    localparam logic [4:0] OP_SUBTRACT = 5'b00001;
    localparam logic [4:0] OP_AND      = 5'b00010;
    localparam logic [4:0] OP_OR       = 5'b00011;
    localparam logic [4:0] OP_SLL      = 5'b00100;
    localparam logic [4:0] OP_SRA      = 5'b00101;
    localparam logic [31:0] RSTATUS_ADD = 32'd1;
    localparam logic [31:0] RSTATUS_SUB = 32'd3;
    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  opcode;
        logic [4:0]  rd;
        logic        ovf;
        logic        ne;
        logic        lt;
    } wb_entry_t;
endpackage

// File: rtl/alu_wb_stage_if.sv
// alu_wb_stage_if: ALU result handshake, register-file write port and committed-state outputs
interface alu_wb_stage_if #(parameter int CNT_W = 16);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_result;
    logic [4:0]       in_opcode;
    logic [4:0]       in_rd;
    logic             in_overflow;
    logic             in_isNotEqual;
    logic             in_isLessThan;
    logic             wb_grant;
    logic             ctrl_writeEnable;
    logic [4:0]       ctrl_writeReg;
    logic [31:0]      data_writeReg;
    logic             last_isNotEqual;
    logic             last_isLessThan;
    logic [CNT_W-1:0] commit_count;
    modport master (
        output in_valid, in_result, in_opcode, in_rd, in_overflow, in_isNotEqual, in_isLessThan, wb_grant,
        input  in_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg, last_isNotEqual, last_isLessThan, commit_count
    );
    modport slave (
        input  in_valid, in_result, in_opcode, in_rd, in_overflow, in_isNotEqual, in_isLessThan, wb_grant,
        output in_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg, last_isNotEqual, last_isLessThan, commit_count
    );
endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: DEPTH-entry circular buffer of writeback entries with registered occupancy count
module wb_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          push,
    input  logic          pop,
    input  wb_entry_t     din,
    output wb_entry_t     head,
    output logic [CW-1:0] count
);
    wb_entry_t mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    assign head = mem[rd_ptr];
    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clock) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
            count  <= count + CW'(push) - CW'(pop);
        end
    end
    // storage needs no reset; entries only become visible through count
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/alu_wb_stage.sv
// alu_wb_stage: buffers ALU results and drains them to the register-file write port on grant.
// Optional macro OVF_RSTATUS_EN redirects ADD/SUBTRACT overflow to the rstatus register.
module alu_wb_stage
    import alu_pkg::*;
#(
    parameter int DEPTH       = 2,
    parameter int RSTATUS_REG = 30,
    parameter int CNT_W       = 16
) (
    input logic           clock,
    input logic           resetn,
    alu_wb_stage_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    wb_entry_t     din;
    wb_entry_t     head;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic          nonempty;
    logic          redir;
    logic          we;
    logic [4:0]    eff_rd;
    logic [31:0]   eff_data;
    assign din = '{
        result: bus.in_result,
        opcode: bus.in_opcode,
        rd:     bus.in_rd,
        ovf:    bus.in_overflow,
        ne:     bus.in_isNotEqual,
        lt:     bus.in_isLessThan
    };
    assign bus.in_ready = count < CW'(DEPTH);
    assign push         = bus.in_valid & bus.in_ready;
    assign nonempty     = count != '0;
`ifdef OVF_RSTATUS_EN
    assign redir    = head.ovf & (head.opcode == OP_ADD | head.opcode == OP_SUBTRACT);
    assign eff_data = redir ? (head.opcode == OP_ADD ? RSTATUS_ADD : RSTATUS_SUB) : head.result;
`else
    logic unused_head;
    assign unused_head = ^{head.ovf, head.opcode};
    assign redir       = 1'b0;
    assign eff_data    = head.result;
`endif
    assign eff_rd               = redir ? 5'(RSTATUS_REG) : head.rd;
    assign we                   = nonempty & bus.wb_grant & (eff_rd != '0);
    assign pop                  = nonempty & (bus.wb_grant | eff_rd == '0);
    assign bus.ctrl_writeEnable = we;
    assign bus.ctrl_writeReg    = nonempty ? eff_rd : '0;
    assign bus.data_writeReg    = nonempty ? eff_data : '0;
    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .resetn(resetn),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .head  (head),
        .count (count)
    );
    // retiring entries update the sticky compare flags; only real writes bump the saturating counter
    always_ff @(posedge clock) begin
        if (!resetn) begin
            bus.last_isNotEqual <= 1'b0;
            bus.last_isLessThan <= 1'b0;
            bus.commit_count    <= '0;
        end else begin
            if (pop) begin
                bus.last_isNotEqual <= head.ne;
                bus.last_isLessThan <= head.lt;
            end
            if (we && !(&bus.commit_count)) bus.commit_count <= bus.commit_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_alu_wb_stage.sv
// tb_alu_wb_stage: directed steps against a queue-based scoreboard model of alu_wb_stage
module tb_alu_wb_stage;
    import alu_pkg::*;
    localparam int DEPTH   = 2;
    localparam int CNT_W   = 4;
    localparam int RSTATUS = 30;
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        ne;
        logic        lt;
    } exp_t;
    logic clock  = 1'b0;
    logic resetn = 1'b0;
    exp_t mq[$];
    logic m_ne = 1'b0;
    logic m_lt = 1'b0;
    logic [CNT_W-1:0] m_cc = '0;
    int checks = 0;
    int errors = 0;
    always #5 clock = ~clock;
    alu_wb_stage_if #(.CNT_W(CNT_W)) bus ();
    alu_wb_stage #(.DEPTH(DEPTH), .RSTATUS_REG(RSTATUS), .CNT_W(CNT_W)) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus)
    );
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    function automatic exp_t model(input logic [31:0] res, input logic [4:0] op, input logic [4:0] rd,
                                   input logic ovf, input logic ne, input logic lt);
        exp_t e;
        logic en;
        logic redirect;
`ifdef OVF_RSTATUS_EN
        en = 1'b1;
`else
        en = 1'b0;
`endif
        redirect = en && ovf && (op == OP_ADD || op == OP_SUBTRACT);
        e.rd   = redirect ? 5'(RSTATUS) : rd;
        e.data = redirect ? (op == OP_ADD ? 32'd1 : 32'd3) : res;
        e.ne   = ne;
        e.lt   = lt;
        return e;
    endfunction
    task automatic drive(input logic v, input logic [31:0] res, input logic [4:0] op, input logic [4:0] rd,
                         input logic ovf, input logic ne, input logic lt);
        bus.in_valid      = v;
        bus.in_result     = res;
        bus.in_opcode     = op;
        bus.in_rd         = rd;
        bus.in_overflow   = ovf;
        bus.in_isNotEqual = ne;
        bus.in_isLessThan = lt;
    endtask
    task automatic cycle();
        exp_t h;
        logic rdy;
        logic ewe;
        logic [4:0] er;
        logic [31:0] ed;
        @(negedge clock);
        rdy = mq.size() < DEPTH;
        ewe = 1'b0;
        er  = '0;
        ed  = '0;
        if (mq.size() > 0) begin
            h   = mq[0];
            er  = h.rd;
            ed  = h.data;
            ewe = bus.wb_grant && h.rd != '0;
        end
        check("in_ready", bus.in_ready, rdy);
        check("write_en", bus.ctrl_writeEnable, ewe);
        check("write_reg", bus.ctrl_writeReg, er);
        check("write_data", bus.data_writeReg, ed);
        check("last_ne", bus.last_isNotEqual, m_ne);
        check("last_lt", bus.last_isLessThan, m_lt);
        check("commit_count", bus.commit_count, m_cc);
        if (mq.size() > 0 && (bus.wb_grant || h.rd == '0)) begin
            m_ne = h.ne;
            m_lt = h.lt;
            if (ewe && m_cc != '1) m_cc++;
            void'(mq.pop_front());
        end
        if (bus.in_valid && rdy)
            mq.push_back(model(bus.in_result, bus.in_opcode, bus.in_rd, bus.in_overflow,
                               bus.in_isNotEqual, bus.in_isLessThan));
        if (!resetn) begin
            mq.delete();
            m_ne = 1'b0;
            m_lt = 1'b0;
            m_cc = '0;
        end
        @(posedge clock);
        #1;
    endtask
    initial begin
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        bus.wb_grant = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        resetn = 1'b1;
        cycle();
        // 1: single write with minimum latency
        bus.wb_grant = 1'b1;
        drive(1'b1, 32'd5, OP_ADD, 5'd3, 1'b0, 1'b1, 1'b0);
        cycle();
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        check("t1_we", bus.ctrl_writeEnable, 1'b1);
        check("t1_reg", bus.ctrl_writeReg, 5'd3);
        check("t1_data", bus.data_writeReg, 32'd5);
        cycle();
        check("t1_count", bus.commit_count, 32'd1);
        // 2: back-pressure when full, then drain in order
        bus.wb_grant = 1'b0;
        drive(1'b1, 32'h11, OP_OR, 5'd4, 1'b0, 1'b0, 1'b1);
        cycle();
        drive(1'b1, 32'h22, OP_AND, 5'd5, 1'b0, 1'b1, 1'b1);
        cycle();
        drive(1'b1, 32'h33, OP_SLL, 5'd6, 1'b0, 1'b0, 1'b0);
        check("t2_full_ready", bus.in_ready, 1'b0);
        cycle();
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        bus.wb_grant = 1'b1;
        check("t2_first_reg", bus.ctrl_writeReg, 5'd4);
        check("t2_first_data", bus.data_writeReg, 32'h11);
        cycle();
        check("t2_second_reg", bus.ctrl_writeReg, 5'd5);
        check("t2_second_data", bus.data_writeReg, 32'h22);
        cycle();
        check("t2_empty_we", bus.ctrl_writeEnable, 1'b0);
        cycle();
        // 3: $r0 entry retires without grant and without a write
        bus.wb_grant = 1'b0;
        drive(1'b1, 32'h99, OP_SRA, 5'd0, 1'b0, 1'b1, 1'b0);
        cycle();
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        check("t3_r0_we", bus.ctrl_writeEnable, 1'b0);
        cycle();
        check("t3_r0_flag", bus.last_isNotEqual, 1'b1);
        check("t3_r0_count", bus.commit_count, 32'd3);
        check("t3_r0_ready", bus.in_ready, 1'b1);
        // 4: overflow handling
        bus.wb_grant = 1'b1;
        drive(1'b1, 32'h8000_0000, OP_ADD, 5'd7, 1'b1, 1'b0, 1'b1);
        cycle();
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
`ifdef OVF_RSTATUS_EN
        check("t4_add_reg", bus.ctrl_writeReg, 5'd30);
        check("t4_add_data", bus.data_writeReg, 32'd1);
`else
        check("t4_add_reg", bus.ctrl_writeReg, 5'd7);
        check("t4_add_data", bus.data_writeReg, 32'h8000_0000);
`endif
        cycle();
        drive(1'b1, 32'h1234, OP_SUBTRACT, 5'd8, 1'b1, 1'b1, 1'b0);
        cycle();
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
`ifdef OVF_RSTATUS_EN
        check("t4_sub_reg", bus.ctrl_writeReg, 5'd30);
        check("t4_sub_data", bus.data_writeReg, 32'd3);
`else
        check("t4_sub_reg", bus.ctrl_writeReg, 5'd8);
        check("t4_sub_data", bus.data_writeReg, 32'h1234);
`endif
        cycle();
        drive(1'b1, 32'h55, OP_AND, 5'd9, 1'b1, 1'b0, 1'b0);
        cycle();
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        check("t4_and_reg", bus.ctrl_writeReg, 5'd9);
        check("t4_and_data", bus.data_writeReg, 32'h55);
        cycle();
        // 5: reset mid-drain discards pending entries
        bus.wb_grant = 1'b0;
        drive(1'b1, 32'hA1, OP_ADD, 5'd10, 1'b0, 1'b1, 1'b1);
        cycle();
        drive(1'b1, 32'hA2, OP_ADD, 5'd11, 1'b0, 1'b0, 1'b1);
        cycle();
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        bus.wb_grant = 1'b1;
        cycle();
        bus.wb_grant = 1'b0;
        resetn = 1'b0;
        cycle();
        resetn = 1'b1;
        bus.wb_grant = 1'b1;
        check("t5_we", bus.ctrl_writeEnable, 1'b0);
        check("t5_ready", bus.in_ready, 1'b1);
        check("t5_count", bus.commit_count, 32'd0);
        repeat (3) cycle();
        // 6: sustained streaming, one write per cycle, counter saturates
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, $urandom, OP_OR, 5'(1 + i % 29), 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            cycle();
        end
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        cycle();
        check("t6_saturated", bus.commit_count, 32'd15);
        check("t6_empty_we", bus.ctrl_writeEnable, 1'b0);
        cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
